// File: rtl/aes_pkg.sv
// Shared definitions for the AES byte-stream front/back end.
package aes_pkg;

    localparam int AES_BLK_W = 128;
    localparam int AES_BYTES = 16;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/aes_byte_serializer.sv
// Loads a 128-bit block and emits it MSB byte first on a valid/ready stream.
module aes_byte_serializer
    import aes_pkg::*;
(
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 load_i,
    input  logic [AES_BLK_W-1:0] data_i,
    input  logic                 m_ready_i,
    output logic [7:0]           m_data_o,
    output logic                 m_valid_o,
    output logic                 last_o
);

    localparam int BCNT_W = $clog2(AES_BYTES);

    logic [AES_BLK_W-1:0] data_q;
    logic [BCNT_W-1:0]    cnt_q;
    logic                 valid_q;
    logic                 xfer;

    assign xfer   = valid_q & m_ready_i;
    assign last_o = xfer & (cnt_q == BCNT_W'(AES_BYTES - 1));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            data_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            cnt_q   <= '0;
            valid_q <= 1'b1;
        end else if (xfer) begin
            // Shifting only on a handshake keeps m_data frozen while stalled.
            data_q <= {data_q[AES_BLK_W-9:0], 8'h00};
            cnt_q  <= cnt_q + 1'b1;
            if (last_o) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign m_data_o  = data_q[AES_BLK_W-1 -: 8];
    assign m_valid_o = valid_q;

endmodule

// File: rtl/aes_byte_stream_if.sv
// Byte-serial key/plaintext collector and ciphertext emitter wrapped around AES_top.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  ST_LOAD  | accept 16 key bytes then 16 plaintext bytes
//  ST_START | one-cycle aes_start pulse, aes_done ignored
//  ST_WAIT  | wait for aes_done, abort to ST_LOAD after TIMEOUT cycles
//  ST_DRAIN | serializer streams the 16 ciphertext bytes out
module aes_byte_stream_if
    import aes_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [7:0]           s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [7:0]           m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 aes_start,
    output logic [AES_BLK_W-1:0] aes_plain_text,
    output logic [AES_BLK_W-1:0] aes_cipher_key,
    input  logic                 aes_done,
    input  logic [AES_BLK_W-1:0] aes_cipher_text,
    output logic                 busy,
    output logic                 err_timeout
);

    state_e               state_q;
    logic [4:0]           in_cnt_q;
    logic [CNT_W-1:0]     to_cnt_q;
    logic [AES_BLK_W-1:0] key_q;
    logic [AES_BLK_W-1:0] pt_q;
    logic                 start_q;
    logic                 err_q;
    logic                 s_fire;
    logic                 ser_load;
    logic                 ser_last;

    assign s_fire   = s_valid & (state_q == ST_LOAD);
    assign ser_load = (state_q == ST_WAIT) & aes_done;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= ST_LOAD;
            in_cnt_q <= '0;
            to_cnt_q <= '0;
            key_q    <= '0;
            pt_q     <= '0;
            start_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (s_fire) begin
                        // Count wraps to 0 on the 32nd byte, ready for the next frame.
                        in_cnt_q <= in_cnt_q + 5'd1;
                        if (!in_cnt_q[4]) begin
                            key_q <= {key_q[AES_BLK_W-9:0], s_data};
                        end else begin
                            pt_q <= {pt_q[AES_BLK_W-9:0], s_data};
                        end
                        if (in_cnt_q == 5'd31) begin
                            state_q <= ST_START;
                            start_q <= 1'b1;
                        end
                    end
                end
                ST_START: begin
                    start_q  <= 1'b0;
                    to_cnt_q <= '0;
                    state_q  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (aes_done) begin
                        state_q <= ST_DRAIN;
                    end else if (to_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        err_q    <= 1'b1;
                        in_cnt_q <= '0;
                        state_q  <= ST_LOAD;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (ser_last) begin
                        state_q <= ST_LOAD;
                    end
                end
                default: state_q <= ST_LOAD;
            endcase
        end
    end

    aes_byte_serializer u_ser (
        .clk       (clk),
        .rstn      (rstn),
        .load_i    (ser_load),
        .data_i    (aes_cipher_text),
        .m_ready_i (m_ready),
        .m_data_o  (m_data),
        .m_valid_o (m_valid),
        .last_o    (ser_last)
    );

    assign s_ready        = (state_q == ST_LOAD);
    assign busy           = (state_q != ST_LOAD);
    assign aes_start      = start_q;
    assign aes_cipher_key = key_q;
    assign aes_plain_text = pt_q;
    assign err_timeout    = err_q;

endmodule
